video_st_source: RTL
====================

VIDEO_ST_SOURCE -- requirements
Module: video_st_source

Interface
REQ-001 SHALL have parameter WIDTH, default 320, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 240, lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of 2, >=4).
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port pix_data  input  24  RGB888 pixel.
REQ-007 SHALL have port pix_valid  input  1  pix_data valid this cycle; no backpressure to the pixel source.
REQ-008 SHALL have port pix_sof  input  1  qualified by pix_valid; marks the first pixel of a frame.
REQ-009 SHALL have port src_data  output  24  Avalon-ST video data to the DMA sink.
REQ-010 SHALL have port src_startofpacket  output  1  first beat of packet.
REQ-011 SHALL have port src_endofpacket  output  1  last beat of packet.
REQ-012 SHALL have port src_valid  output  1  beat valid.
REQ-013 SHALL have port src_ready  input  1  sink ready, readyLatency 0.
REQ-014 SHALL have port err_clr  input  1  clears err.
REQ-015 SHALL have port err  output  1  sticky frame error (overflow or early SOF).
REQ-016 SHALL have port frame_count  output  16  completed packets, wraps 0xFFFF->0.

Function
REQ-017 SHALL implement states IDLE, HEADER, STREAM, PAD.
REQ-018 IDLE: SHALL discard pix_valid without pix_sof; pix_valid&&pix_sof SHALL write that pixel to FIFO, zero write/read counters (write count becomes 1), go HEADER.
REQ-019 HEADER: SHALL present src_valid=1, src_startofpacket=1, src_data=24'h000000 (packet type 0, video); on src_ready go STREAM.
REQ-020 Input SHALL be written to FIFO in HEADER/STREAM while write count < WIDTH*HEIGHT; pixels beyond WIDTH*HEIGHT before the next SOF SHALL be discarded silently.
REQ-021 STREAM: src_valid SHALL equal FIFO non-empty; src_data SHALL be FIFO head; a beat transfers when src_valid&&src_ready, popping FIFO and incrementing read count.
REQ-022 src_endofpacket SHALL be 1 exactly on the beat with read count == WIDTH*HEIGHT-1; after its transfer: frame_count+1, go IDLE.
REQ-023 Write to full FIFO (pixel lost) SHALL set err and go PAD.
REQ-024 pix_valid&&pix_sof in HEADER/STREAM (write count < WIDTH*HEIGHT) SHALL be discarded, set err, go PAD.
REQ-025 PAD: SHALL discard all input; SHALL drain remaining FIFO contents, then emit src_data=0 beats until the total is WIDTH*HEIGHT pixel beats, with eop on last; then IDLE. Packet length SHALL always be 1+WIDTH*HEIGHT beats.
REQ-026 While src_valid=1 and src_ready=0, src_data/sop/eop SHALL hold stable; src_valid SHALL not deassert before transfer.
REQ-027 Simultaneous FIFO write and read SHALL both occur; full is evaluated before the same-cycle pop (conservative).
REQ-028 err SHALL clear on err_clr; a same-cycle set SHALL win over clear.
REQ-029 Pixel-input-to-src_valid latency SHALL be 1 cycle from empty FIFO in STREAM.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, FIFO empty, counters 0, src_valid/sop/eop=0, src_data=0, err=0, frame_count=0.
REQ-031 Reset mid-packet SHALL abandon the packet; no eop is emitted; first post-reset packet SHALL start only on a new pix_sof.

Verification
REQ-032 WIDTH=4,HEIGHT=2, src_ready=1, 8 pixels 1..8 with sof on 1 -> beats: 0x000000(sop), 1..8, eop on 8; frame_count=1, err=0.
REQ-033 Same stimulus, src_ready toggling 1,0 -> identical beat sequence, data stable during stalls, no loss.
REQ-034 FIFO_DEPTH=4, src_ready=0 until 6 pixels sent -> err=1, packet = header, pixels 1..4, four 0x000000, eop on 8th pixel beat.
REQ-035 sof on pixel 3 of a frame -> err=1, padded to 8 pixel beats with eop; next sof starts clean packet, frame_count=2.
REQ-036 reset_n low after 3 pixel beats -> outputs 0 next edge; subsequent full frame yields normal packet, frame_count=1.
REQ-037 Pixels without sof in IDLE, then err_clr with err=1 and no new error -> no output beats; err=0.

Source files
------------

// File: rtl/video_st_source.sv
// rtl/video_st_source.sv - pixel stream to Avalon-ST video packet source with FIFO, padding and frame counting
module video_st_source #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic [23:0] src_data,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic        src_valid,
    input  logic        src_ready,
    input  logic        err_clr,
    output logic        err,
    output logic [15:0] frame_count
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HEADER, STREAM, PAD} state_t;

    state_t         state_q;
    logic [23:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    cnt_q, cnt_d;
    logic [CW-1:0]  wcnt_q, rcnt_q;
    logic           bad_q;
    logic           err_q;
    logic [15:0]    frame_q;

    logic fifo_empty, fifo_full, last_beat, in_window;
    logic push_idle, push_mid, push, pop, xfer;
    logic sof_err, ovf, err_set;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign last_beat  = (rcnt_q == CW'(NPIX - 1));

    // A header that has already seen an error stops accepting pixels so the
    // packet can fall straight into padding once the header beat is taken.
    assign in_window = ((state_q == HEADER && !bad_q) || state_q == STREAM)
                       && (wcnt_q < CW'(NPIX));

    assign push_idle = (state_q == IDLE) && pix_valid && pix_sof;
    assign sof_err   = in_window && pix_valid && pix_sof;
    assign ovf       = in_window && pix_valid && !pix_sof && fifo_full;
    assign push_mid  = in_window && pix_valid && !pix_sof && !fifo_full;
    assign push      = push_idle || push_mid;
    assign err_set   = sof_err || ovf;

    assign src_valid = (state_q == HEADER) || (state_q == PAD)
                       || (state_q == STREAM && !fifo_empty);
    assign src_startofpacket = (state_q == HEADER);
    assign src_endofpacket   = src_valid && (state_q == STREAM || state_q == PAD) && last_beat;
    assign src_data  = ((state_q == STREAM || state_q == PAD) && !fifo_empty)
                       ? mem_q[rd_ptr_q] : 24'h000000;

    assign xfer = src_valid && src_ready;
    assign pop  = xfer && (state_q == STREAM || state_q == PAD) && !fifo_empty;

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!push && pop)
            cnt_d = cnt_q - 1'b1;
    end

    // Pixel storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= pix_data;
    end

    // Packet FSM, FIFO pointers, beat/pixel counters, sticky error and frame count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
            frame_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;

            if (err_set)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;

            if (push_mid)
                wcnt_q <= wcnt_q + 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (push_idle) begin
                        wcnt_q  <= CW'(1);
                        rcnt_q  <= '0;
                        bad_q   <= 1'b0;
                        state_q <= HEADER;
                    end
                end
                HEADER: begin
                    if (err_set)
                        bad_q <= 1'b1;
                    if (xfer)
                        state_q <= (bad_q || err_set) ? PAD : STREAM;
                end
                STREAM: begin
                    if (xfer)
                        rcnt_q <= rcnt_q + 1'b1;
                    if (xfer && last_beat) begin
                        frame_q <= frame_q + 1'b1;
                        state_q <= IDLE;
                    end else if (err_set) begin
                        state_q <= PAD;
                    end
                end
                PAD: begin
                    if (xfer)
                        rcnt_q <= rcnt_q + 1'b1;
                    if (xfer && last_beat) begin
                        frame_q <= frame_q + 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign err         = err_q;
    assign frame_count = frame_q;
endmodule
